// File: rtl/csr_ctrl.sv
// Sequencer owning the machine-mode CSR port: Zicsr read-modify-write plus
// ECALL/MRET trap sequences, one CSR access per cycle, response held until taken.
module csr_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_src,
  input  logic        req_src_zero,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect,
  output logic [31:0] resp_target,
  output logic [11:0] csr_addr,
  output logic        csr_we,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata
);

  localparam logic [2:0] OP_CSRRW = 3'b001;
  localparam logic [2:0] OP_CSRRS = 3'b010;
  localparam logic [2:0] OP_CSRRC = 3'b011;
  localparam logic [2:0] OP_ECALL = 3'b100;
  localparam logic [2:0] OP_MRET  = 3'b101;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  typedef enum logic [3:0] {
    IDLE, ZICSR, EC_EPC, EC_CAUSE, EC_STATUS, EC_VEC, MR_STATUS, MR_EPC, RESP
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [11:0] addr_reg;
  logic [31:0] src_reg;
  logic        src_zero_reg;
  logic [31:0] pc_reg;
  logic [31:0] rdata_reg;
  logic        redirect_reg;
  logic [31:0] target_reg;

  logic [31:0] ec_status;
  logic [31:0] mr_status;

  // Trap entry stacks MIE into MPIE; trap return restores it. MPP is always M.
  always_comb begin
    ec_status        = csr_rdata;
    ec_status[7]     = csr_rdata[3];
    ec_status[3]     = 1'b0;
    ec_status[12:11] = 2'b11;
    mr_status        = csr_rdata;
    mr_status[3]     = csr_rdata[7];
    mr_status[7]     = 1'b1;
    mr_status[12:11] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      op_reg       <= '0;
      addr_reg     <= '0;
      src_reg      <= '0;
      src_zero_reg <= 1'b0;
      pc_reg       <= '0;
      rdata_reg    <= '0;
      redirect_reg <= 1'b0;
      target_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        op_reg       <= req_op;
        addr_reg     <= req_addr;
        src_reg      <= req_src;
        src_zero_reg <= req_src_zero;
        pc_reg       <= req_pc;
        rdata_reg    <= '0;
        redirect_reg <= 1'b0;
        target_reg   <= '0;
      end
      case (state_reg)
        ZICSR:  rdata_reg <= csr_rdata;
        EC_VEC: begin
          target_reg   <= {csr_rdata[31:2], 2'b00};
          redirect_reg <= 1'b1;
        end
        MR_EPC: begin
          target_reg   <= csr_rdata;
          redirect_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    csr_addr   = '0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_next = ZICSR;
            OP_ECALL:                     state_next = EC_EPC;
            OP_MRET:                      state_next = MR_STATUS;
            default:                      state_next = RESP;
          endcase
        end
      end
      ZICSR: begin
        csr_addr   = addr_reg;
        state_next = RESP;
        case (op_reg)
          OP_CSRRW: begin
            csr_we    = 1'b1;
            csr_wdata = src_reg;
          end
          OP_CSRRS: begin
            csr_we    = !src_zero_reg;
            csr_wdata = csr_rdata | src_reg;
          end
          OP_CSRRC: begin
            csr_we    = !src_zero_reg;
            csr_wdata = csr_rdata & ~src_reg;
          end
          default: ;
        endcase
      end
      EC_EPC: begin
        csr_addr   = ADDR_MEPC;
        csr_we     = 1'b1;
        csr_wdata  = pc_reg;
        state_next = EC_CAUSE;
      end
      EC_CAUSE: begin
        csr_addr   = ADDR_MCAUSE;
        csr_we     = 1'b1;
        csr_wdata  = 32'd11;
        state_next = EC_STATUS;
      end
      EC_STATUS: begin
        csr_addr   = ADDR_MSTATUS;
        csr_we     = 1'b1;
        csr_wdata  = ec_status;
        state_next = EC_VEC;
      end
      EC_VEC: begin
        csr_addr   = ADDR_MTVEC;
        state_next = RESP;
      end
      MR_STATUS: begin
        csr_addr   = ADDR_MSTATUS;
        csr_we     = 1'b1;
        csr_wdata  = mr_status;
        state_next = MR_EPC;
      end
      MR_EPC: begin
        csr_addr   = ADDR_MEPC;
        state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid    = (state_reg == RESP);
  assign resp_rdata    = rdata_reg;
  assign resp_redirect = redirect_reg;
  assign resp_target   = target_reg;

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard bench for csr_ctrl: a behavioural CSR model predicts responses,
// CSR writes and latencies; a CSR file model and a response monitor check them.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_src = '0;
  logic        req_src_zero = 1'b0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_target;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  always #5 clk = ~clk;

  csr_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_src(req_src), .req_src_zero(req_src_zero),
    .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_target(resp_target),
    .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit force_hold = 1'b0;

  typedef struct {logic [11:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic [31:0] rdata; logic redirect; logic [31:0] target; int lat;} rsp_t;
  wr_t  exp_w[$];
  rsp_t exp_q[$];
  logic [31:0] ref_csr [int];

  // CSR file seen by the DUT: combinational read, write at posedge
  logic [31:0] f_mstatus = 32'h1800;
  logic [31:0] f_mtvec   = 32'h0;
  logic [31:0] f_mepc    = 32'h0;
  logic [31:0] f_mcause  = 32'h0;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = f_mstatus;
      12'h305: csr_rdata = f_mtvec;
      12'h341: csr_rdata = f_mepc;
      12'h342: csr_rdata = f_mcause;
      default: csr_rdata = 32'h0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] ref_rd(input int a);
    return ref_csr.exists(a) ? ref_csr[a] : 32'h0;
  endfunction

  function automatic void ref_wr(input int a, input logic [31:0] d);
    wr_t w;
    if (ref_csr.exists(a)) ref_csr[a] = d;
    w.a = 12'(a);
    w.d = d;
    exp_w.push_back(w);
  endfunction

  // Architectural effect of one instruction on the CSR set
  task automatic model(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                       input logic sz, input logic [31:0] pc);
    rsp_t r;
    logic [31:0] old, s;
    r.rdata = 0; r.redirect = 0; r.target = 0; r.lat = 2;
    old = ref_rd(int'(a));
    case (op)
      3'b001: begin r.rdata = old; ref_wr(int'(a), src); end
      3'b010: begin r.rdata = old; if (!sz) ref_wr(int'(a), old | src); end
      3'b011: begin r.rdata = old; if (!sz) ref_wr(int'(a), old & ~src); end
      3'b100: begin
        ref_wr('h341, pc);
        ref_wr('h342, 32'd11);
        s = ref_rd('h300);
        ref_wr('h300, (s & ~32'h1888) | 32'h1800 | ((s & 32'h8) << 4));
        r.redirect = 1;
        r.target = ref_rd('h305) & ~32'h3;
        r.lat = 5;
      end
      3'b101: begin
        s = ref_rd('h300);
        ref_wr('h300, (s & ~32'h8) | 32'h1880 | ((s >> 4) & 32'h8));
        r.redirect = 1;
        r.target = ref_rd('h341);
        r.lat = 3;
      end
      default: r.lat = 1;
    endcase
    exp_q.push_back(r);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
      if (req_valid && req_ready && !rst) acc_cyc <= cyc + 1;
    end
  end

  // Write scoreboard and CSR file update
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      if (csr_we) begin
        if (exp_w.size() == 0) begin
          fail("unexpected_csr_write");
        end else begin
          w = exp_w.pop_front();
          chk("csr_write_addr", {20'h0, csr_addr}, {20'h0, w.a});
          chk("csr_write_data", csr_wdata, w.d);
        end
        case (csr_addr)
          12'h300: f_mstatus <= csr_wdata;
          12'h305: f_mtvec   <= csr_wdata;
          12'h341: f_mepc    <= csr_wdata;
          12'h342: f_mcause  <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  // Response monitor and consumer
  initial begin
    rsp_t e;
    bit in_resp = 0;
    int hold = 0;
    resp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        resp_ready = 1'b0;
        in_resp = 0;
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_response");
          resp_ready = 1'b1;
        end else begin
          e = exp_q[0];
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_redirect", {31'h0, resp_redirect}, {31'h0, e.redirect});
          chk("resp_target", resp_target, e.target);
          chk("ready_in_resp", {31'h0, req_ready}, 32'h0);
          if (!in_resp) begin
            chk("latency", 32'(cyc - acc_cyc + 1), 32'(e.lat));
            in_resp = 1;
            hold = force_hold ? 4 : $urandom_range(0, 2);
          end
          if (hold == 0) begin
            resp_ready = 1'b1;
            void'(exp_q.pop_front());
            in_resp = 0;
          end else begin
            hold--;
            resp_ready = 1'b0;
          end
        end
      end else begin
        resp_ready = 1'b0;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [31:0] src,
                       input logic sz, input logic [31:0] pc);
    int n = 0;
    model(op, a, src, sz, pc);
    req_op = op; req_addr = a; req_src = src; req_src_zero = sz; req_pc = pc;
    req_valid = 1'b1;
    while (!req_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_after_accept", {31'h0, req_ready}, 32'h0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_w.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_w.size() != 0) fail("drain_timeout");
  endtask

  task automatic cmp_file();
    chk("mstatus", f_mstatus, ref_rd('h300));
    chk("mtvec", f_mtvec, ref_rd('h305));
    chk("mepc", f_mepc, ref_rd('h341));
    chk("mcause", f_mcause, ref_rd('h342));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [2:0] op;
    logic [11:0] a;
    logic sz;
    ref_csr['h300] = 32'h1800;
    ref_csr['h305] = 32'h0;
    ref_csr['h341] = 32'h0;
    ref_csr['h342] = 32'h0;

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_redirect", {31'h0, resp_redirect}, 32'h0);
    chk("rst_resp_target", resp_target, 32'h0);
    chk("rst_csr_we", {31'h0, csr_we}, 32'h0);
    chk("rst_csr_addr", {20'h0, csr_addr}, 32'h0);
    chk("rst_csr_wdata", csr_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

    // CSRRS with zero source: pure read, no write
    issue(3'b010, 12'h300, 32'h0, 1'b1, 32'h0);
    drain();
    issue(3'b001, 12'h305, 32'h80000100, 1'b0, 32'h0);
    issue(3'b011, 12'h305, 32'h100, 1'b0, 32'h0);
    drain();
    chk("mtvec_after_rc", f_mtvec, 32'h80000000);

    // Trap entry and return
    issue(3'b001, 12'h300, 32'h1808, 1'b0, 32'h0);
    issue(3'b001, 12'h305, 32'h80000103, 1'b0, 32'h0);
    issue(3'b100, 12'h000, 32'h0, 1'b0, 32'h80000040);
    drain();
    chk("mstatus_after_ecall", f_mstatus, 32'h1880);
    chk("mepc_after_ecall", f_mepc, 32'h80000040);
    chk("mcause_after_ecall", f_mcause, 32'd11);
    issue(3'b101, 12'h000, 32'h0, 1'b0, 32'h0);
    drain();
    chk("mstatus_after_mret", f_mstatus, 32'h1888);

    // Illegal ops and a write to an unknown address
    issue(3'b000, 12'h300, 32'hffff, 1'b0, 32'h0);
    issue(3'b111, 12'h300, 32'hffff, 1'b0, 32'h0);
    issue(3'b001, 12'hc00, 32'h1234, 1'b0, 32'h0);
    drain();
    cmp_file();

    // Stalled consumer with a request waiting behind it
    force_hold = 1'b1;
    issue(3'b010, 12'h341, 32'h0, 1'b1, 32'h0);
    issue(3'b110, 12'h000, 32'h0, 1'b0, 32'h0);
    force_hold = 1'b0;
    drain();

    // Reset during EC_CAUSE: mepc and mcause land, mstatus untouched
    ref_wr('h341, 32'h00000abc);
    ref_wr('h342, 32'd11);
    req_op = 3'b100; req_pc = 32'h00000abc; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("ec_epc_addr", {20'h0, csr_addr}, 32'h341);
    @(negedge clk);
    chk("ec_cause_addr", {20'h0, csr_addr}, 32'h342);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ready_after_mid_rst", {31'h0, req_ready}, 32'h1);
    chk("pending_writes_after_rst", 32'(exp_w.size()), 32'h0);
    repeat (3) begin
      chk("no_resp_after_rst", {31'h0, resp_valid}, 32'h0);
      @(negedge clk);
    end
    cmp_file();

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: op = 3'b001;
        2, 3: op = 3'b010;
        4, 5: op = 3'b011;
        6:    op = 3'b100;
        7:    op = 3'b101;
        8:    op = 3'b000;
        default: op = 3'($urandom_range(6, 7));
      endcase
      case ($urandom_range(0, 4))
        0: a = 12'h300;
        1: a = 12'h305;
        2: a = 12'h341;
        3: a = 12'h342;
        default: a = 12'($urandom);
      endcase
      sz = ($urandom_range(0, 3) == 0);
      issue(op, a, sz ? 32'h0 : $urandom, sz, $urandom & 32'hfffffffc);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i % 25 == 24) begin
        drain();
        cmp_file();
      end
    end
    drain();
    cmp_file();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
